uart_receiver_controller: RTL

UART_RECEIVER_CONTROLLER -- requirements
Module: uart_receiver_controller

---
 rtl/uart_receiver_controller_pkg.sv | 31 +++
 rtl/uart_receiver_controller_rx_frame_timer.sv | 43 ++++
 rtl/uart_receiver_controller.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/uart_receiver_controller_pkg.sv
// Shared definitions for the UART receiver command controller.
// Contents: frame command codes, FSM state encoding, fixed ALU operand
// register addresses, and a helper that reports clock-gated states.
package uart_receiver_controller_pkg;

  localparam logic [7:0] CMD_RF_WR  = 8'hAA;
  localparam logic [7:0] CMD_RF_RD  = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  // Register-file locations that receive ALU operands A and B.
  localparam int unsigned OP_A_ADDR = 0;
  localparam int unsigned OP_B_ADDR = 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_OP_A    = 3'd4,
    ST_OP_B    = 3'd5,
    ST_FUNC    = 3'd6,
    ST_EXEC    = 3'd7
  } rx_state_e;

  // The ALU clock is ungated while a function byte is awaited or executing.
  function automatic logic is_gated_state(rx_state_e s);
    return (s == ST_FUNC) || (s == ST_EXEC);
  endfunction

endpackage

// File: rtl/uart_receiver_controller_rx_frame_timer.sv
// rx_frame_timer: inter-byte gap timer for the UART receiver controller.
// Built only when RX_TIMEOUT_EN is defined.
// Ports:
//   clk, rst_n  - system clock, async active-low reset
//   run_i       - controller is mid-frame and waiting for a byte
//   clear_i     - reload the counter (byte seen, or not running)
//   expired_o   - gap has reached TIMEOUT_CYCLES
`ifdef RX_TIMEOUT_EN
module rx_frame_timer #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;

  // Down-counter reloaded on every byte; terminal count flags expiry on the
  // TIMEOUT_CYCLES-th edge after the last accepted byte.
  always_comb begin
    count_d = count_q;
    if (clear_i || !run_i) begin
      count_d = LOAD_VAL;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= LOAD_VAL;
    else        count_q <= count_d;
  end

  assign expired_o = run_i && !clear_i && (count_q == '0);

endmodule
`endif

// File: rtl/uart_receiver_controller.sv
// uart_receiver_controller: decodes byte frames from a UART receiver into
// register-file writes/reads and ALU execute requests.
// Frames: AA,addr,data | BB,addr | CC,A,B,func | DD,func
// Ports:
//   clk, reset                        - system clock, async active-low reset
//   receiver_parallel_data_valid/data - one-cycle strobe plus received byte
//   UART_receiver_controller_enable   - permits starting a new frame
//   address, write_enable, write_data, read_enable - register-file side
//   ALU_enable, ALU_function, clock_gate_enable    - ALU side
// All outputs are registered (one cycle after the accepted byte).
// Optional: define RX_TIMEOUT_EN to abandon a frame after TIMEOUT_CYCLES
// idle cycles (rx_frame_timer).
//
// state    | meaning
// ---------+------------------------------------------------
// IDLE     | waiting for a command byte (enable gates entry)
// WR_ADDR  | RF write: waiting for address byte
// WR_DATA  | RF write: waiting for data byte
// RD_ADDR  | RF read: waiting for address byte
// OP_A     | ALU op: waiting for operand A (stored at addr 0)
// OP_B     | ALU op: waiting for operand B (stored at addr 1)
// FUNC     | waiting for ALU function byte, ALU clock ungated
// EXEC     | ALU_enable cycle, incoming bytes ignored
module uart_receiver_controller
  import uart_receiver_controller_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDRESS_WIDTH  = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     receiver_parallel_data_valid,
  input  logic [DATA_WIDTH-1:0]    receiver_parallel_data,
  input  logic                     UART_receiver_controller_enable,
  output logic [ADDRESS_WIDTH-1:0] address,
  output logic                     write_enable,
  output logic [DATA_WIDTH-1:0]    write_data,
  output logic                     read_enable,
  output logic                     ALU_enable,
  output logic [3:0]               ALU_function,
  output logic                     clock_gate_enable
);

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  rx_state_e state_q, state_d;

  logic [ADDRESS_WIDTH-1:0] address_q, address_d;
  logic [DATA_WIDTH-1:0]    write_data_q, write_data_d;
  logic [3:0]               alu_function_q, alu_function_d;
  logic write_enable_q, write_enable_d;
  logic read_enable_q, read_enable_d;
  logic alu_enable_q, alu_enable_d;
  logic clock_gate_enable_q, clock_gate_enable_d;

  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] rx_byte;
  logic                  timer_expired;

  assign rx_valid = receiver_parallel_data_valid;
  assign rx_byte  = receiver_parallel_data;

`ifdef RX_TIMEOUT_EN
  logic timer_run;
  assign timer_run = (state_q != ST_IDLE) && (state_q != ST_EXEC);

  rx_frame_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx_frame_timer (
    .clk       (clk),
    .rst_n     (reset),
    .run_i     (timer_run),
    .clear_i   (rx_valid),
    .expired_o (timer_expired)
  );
`else
  assign timer_expired = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    address_d      = address_q;
    write_data_d   = write_data_q;
    alu_function_d = alu_function_q;
    write_enable_d = 1'b0;
    read_enable_d  = 1'b0;
    alu_enable_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_valid && UART_receiver_controller_enable) begin
          if      (rx_byte == DATA_WIDTH'(CMD_RF_WR))   state_d = ST_WR_ADDR;
          else if (rx_byte == DATA_WIDTH'(CMD_RF_RD))   state_d = ST_RD_ADDR;
          else if (rx_byte == DATA_WIDTH'(CMD_ALU_OP))  state_d = ST_OP_A;
          else if (rx_byte == DATA_WIDTH'(CMD_ALU_NOP)) state_d = ST_FUNC;
        end
      end
      ST_WR_ADDR: begin
        if (rx_valid) begin
          address_d = rx_byte[ADDRESS_WIDTH-1:0];
          state_d   = ST_WR_DATA;
        end
      end
      ST_WR_DATA: begin
        if (rx_valid) begin
          write_enable_d = 1'b1;
          write_data_d   = rx_byte;
          state_d        = ST_IDLE;
        end
      end
      ST_RD_ADDR: begin
        if (rx_valid) begin
          read_enable_d = 1'b1;
          address_d     = rx_byte[ADDRESS_WIDTH-1:0];
          state_d       = ST_IDLE;
        end
      end
      ST_OP_A: begin
        if (rx_valid) begin
          write_enable_d = 1'b1;
          write_data_d   = rx_byte;
          address_d      = ADDRESS_WIDTH'(OP_A_ADDR);
          state_d        = ST_OP_B;
        end
      end
      ST_OP_B: begin
        if (rx_valid) begin
          write_enable_d = 1'b1;
          write_data_d   = rx_byte;
          address_d      = ADDRESS_WIDTH'(OP_B_ADDR);
          state_d        = ST_FUNC;
        end
      end
      ST_FUNC: begin
        if (rx_valid) begin
          // ALU_enable is registered, so it lands exactly in the EXEC cycle.
          alu_function_d = rx_byte[3:0];
          alu_enable_d   = 1'b1;
          state_d        = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A stalled frame is dropped without any strobe.
    if (timer_expired) state_d = ST_IDLE;

    // Registered from the next state so the gate tracks FUNC/EXEC exactly.
    clock_gate_enable_d = is_gated_state(state_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q             <= ST_IDLE;
      address_q           <= '0;
      write_data_q        <= '0;
      alu_function_q      <= '0;
      write_enable_q      <= 1'b0;
      read_enable_q       <= 1'b0;
      alu_enable_q        <= 1'b0;
      clock_gate_enable_q <= 1'b0;
    end else begin
      state_q             <= state_d;
      address_q           <= address_d;
      write_data_q        <= write_data_d;
      alu_function_q      <= alu_function_d;
      write_enable_q      <= write_enable_d;
      read_enable_q       <= read_enable_d;
      alu_enable_q        <= alu_enable_d;
      clock_gate_enable_q <= clock_gate_enable_d;
    end
  end

  assign address           = address_q;
  assign write_enable      = write_enable_q;
  assign write_data        = write_data_q;
  assign read_enable       = read_enable_q;
  assign ALU_enable        = alu_enable_q;
  assign ALU_function      = alu_function_q;
  assign clock_gate_enable = clock_gate_enable_q;

endmodule
